// File: rtl/pulse_stretcher.sv
// Stretches trigger edges into pulses with a minimum high time and minimum low gap, counted in enabled cycles.
// Optional request queue when PULSE_STRETCHER_QUEUE_EN is defined; otherwise busy-time requests are dropped.
module pulse_stretcher #(
    parameter int WIDTH       = 8,
    parameter int HIGH_CYCLES = 200,
    parameter int LOW_CYCLES  = 100,
    parameter int QUEUE_WIDTH = 4
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   clk_enable,
    input  logic                   trigger,
    output logic                   pulse_out,
    output logic                   busy,
    output logic [QUEUE_WIDTH-1:0] pending,
    output logic                   overflow
);

    localparam logic [1:0] S_IDLE   = 2'd0;
    localparam logic [1:0] S_ACTIVE = 2'd1;
    localparam logic [1:0] S_GAP    = 2'd2;

    localparam logic [WIDTH-1:0] HIGH_LOAD = WIDTH'(HIGH_CYCLES - 1);
    localparam logic [WIDTH-1:0] LOW_LOAD  = WIDTH'(LOW_CYCLES - 1);

    logic [1:0]       state, state_nx;
    logic [WIDTH-1:0] counter, counter_nx;
    logic             pulse_nx;
    logic             trigger_q;
    logic             req;
    logic             busy_req;   // request arriving that cannot start a pulse directly
    logic             dequeue;    // a queued request starts a pulse this cycle
    logic             lost;

    assign req = trigger & ~trigger_q;

    always_comb begin
        state_nx   = state;
        counter_nx = counter;
        pulse_nx   = pulse_out;
        busy_req   = 1'b0;
        dequeue    = 1'b0;
        case (state)
            S_IDLE: begin
                if (req) begin
                    state_nx   = S_ACTIVE;
                    pulse_nx   = 1'b1;
                    counter_nx = HIGH_LOAD;
                end
            end
            S_ACTIVE: begin
                busy_req = req;
                if (counter == '0) begin
                    state_nx   = S_GAP;
                    pulse_nx   = 1'b0;
                    counter_nx = LOW_LOAD;
                end else begin
                    counter_nx = counter - WIDTH'(1);
                end
            end
            S_GAP: begin
                if (counter != '0) begin
                    busy_req   = req;
                    counter_nx = counter - WIDTH'(1);
                end else if (pending != '0) begin
                    // A request in the same cycle replaces the one dequeued.
                    busy_req   = req;
                    dequeue    = 1'b1;
                    state_nx   = S_ACTIVE;
                    pulse_nx   = 1'b1;
                    counter_nx = HIGH_LOAD;
                end else if (req) begin
                    state_nx   = S_ACTIVE;
                    pulse_nx   = 1'b1;
                    counter_nx = HIGH_LOAD;
                end else begin
                    state_nx = S_IDLE;
                end
            end
            default: begin
                state_nx = S_IDLE;
                pulse_nx = 1'b0;
            end
        endcase
    end

`ifdef PULSE_STRETCHER_QUEUE_EN
    localparam logic [QUEUE_WIDTH-1:0] PEND_MAX = {QUEUE_WIDTH{1'b1}};

    assign lost = busy_req & ~dequeue & (pending == PEND_MAX);

    always_ff @(posedge clk) begin
        if (reset) begin
            pending <= '0;
        end else if (clk_enable) begin
            if (busy_req && !dequeue && pending != PEND_MAX) begin
                pending <= pending + QUEUE_WIDTH'(1);
            end else if (dequeue && !busy_req) begin
                pending <= pending - QUEUE_WIDTH'(1);
            end
        end
    end
`else
    assign pending = '0;
    assign lost    = busy_req & ~dequeue;
`endif

    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= S_IDLE;
            busy      <= 1'b0;
            counter   <= '0;
            pulse_out <= 1'b0;
            overflow  <= 1'b0;
            trigger_q <= 1'b1;
        end else if (clk_enable) begin
            trigger_q <= trigger;
            state     <= state_nx;
            busy      <= (state_nx != S_IDLE);
            counter   <= counter_nx;
            pulse_out <= pulse_nx;
            if (lost) begin
                overflow <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_pulse_stretcher.sv
// Directed bench: short-pulse instance (HIGH=3, LOW=2) and long-pulse instance (HIGH=12, LOW=3), both QUEUE_WIDTH=2.
module tb_pulse_stretcher;

    logic       clk = 1'b0;
    logic       reset;
    logic       clk_enable;
    logic       trigger;
    logic       trigger_l;
    logic       pulse_out, busy, overflow;
    logic [1:0] pending;
    logic       pulse_l, busy_l, overflow_l;
    logic [1:0] pending_l;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    pulse_stretcher #(.WIDTH(8), .HIGH_CYCLES(3), .LOW_CYCLES(2), .QUEUE_WIDTH(2)) dut (
        .clk(clk), .reset(reset), .clk_enable(clk_enable), .trigger(trigger),
        .pulse_out(pulse_out), .busy(busy), .pending(pending), .overflow(overflow)
    );

    pulse_stretcher #(.WIDTH(8), .HIGH_CYCLES(12), .LOW_CYCLES(3), .QUEUE_WIDTH(2)) dut_l (
        .clk(clk), .reset(reset), .clk_enable(clk_enable), .trigger(trigger_l),
        .pulse_out(pulse_l), .busy(busy_l), .pending(pending_l), .overflow(overflow_l)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        reset = 1'b1; clk_enable = 1'b1; trigger = 1'b1; trigger_l = 1'b0;
        for (int i = 0; i < 5; i++) tick();
        n_checks++;
        if (pulse_out !== 1'b0 || busy !== 1'b0 || pending !== 2'd0 || overflow !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_state: pulse=%b busy=%b pending=%0d overflow=%b, required 0 0 0 0",
                     pulse_out, busy, pending, overflow);
        end
        reset = 1'b0;
        for (int i = 0; i < 3; i++) begin
            tick();
            n_checks++;
            if (pulse_out !== 1'b0 || busy !== 1'b0) begin
                n_fail++;
                $display("FAIL held_trigger cycle %0d: pulse=%b busy=%b, required 0 0", i, pulse_out, busy);
            end
        end
        trigger = 1'b0;
        tick(); tick();
        n_checks++;
        if (pulse_out !== 1'b0 || busy !== 1'b0) begin
            n_fail++;
            $display("FAIL release_after_reset: pulse=%b busy=%b, required 0 0", pulse_out, busy);
        end
    endtask

    task automatic test_basic();
        int highs = 0, busys = 0, first = -1;
        trigger = 1'b1;
        for (int i = 0; i < 10; i++) begin
            tick();
            trigger = 1'b0;
            if (pulse_out === 1'b1) begin
                highs++;
                if (first < 0) first = i;
            end
            if (busy === 1'b1) busys++;
        end
        n_checks++;
        if (first !== 0) begin
            n_fail++;
            $display("FAIL basic_latency: first high at tick %0d, required 0", first);
        end
        n_checks++;
        if (highs !== 3) begin
            n_fail++;
            $display("FAIL basic_high_len: %0d cycles, required 3", highs);
        end
        n_checks++;
        if (busys !== 5) begin
            n_fail++;
            $display("FAIL basic_busy_len: %0d cycles, required 5", busys);
        end
        n_checks++;
        if (overflow !== 1'b0) begin
            n_fail++;
            $display("FAIL basic_overflow: %b, required 0", overflow);
        end
    endtask

    task automatic test_clk_enable();
        int early = 0, highs = 0, first = -1;
        for (int i = 0; i < 48; i++) begin
            clk_enable = (i % 4 == 0);
            trigger    = (i == 1 || i == 2 || i >= 18);
            tick();
            if (pulse_out === 1'b1) begin
                highs++;
                if (first < 0) first = i;
                if (i < 20) early++;
            end
        end
        n_checks++;
        if (early !== 0) begin
            n_fail++;
            $display("FAIL ce_glitch_ignored: %0d early high cycles, required 0", early);
        end
        n_checks++;
        if (first !== 20) begin
            n_fail++;
            $display("FAIL ce_pulse_start: tick %0d, required 20", first);
        end
        n_checks++;
        if (highs !== 12) begin
            n_fail++;
            $display("FAIL ce_pulse_len: %0d clk cycles, required 12", highs);
        end
        n_checks++;
        if (busy !== 1'b0) begin
            n_fail++;
            $display("FAIL ce_back_idle: busy=%b, required 0", busy);
        end
        clk_enable = 1'b1;
        trigger    = 1'b0;
        tick(); tick();
    endtask

`ifndef PULSE_STRETCHER_QUEUE_EN
    task automatic test_no_queue();
        int rises = 0;
        logic prev = 1'b0;
        for (int j = 0; j < 12; j++) begin
            trigger = (j == 0 || j == 2);
            tick();
            if (pulse_out === 1'b1 && prev === 1'b0) rises++;
            prev = pulse_out;
        end
        n_checks++;
        if (rises !== 1) begin
            n_fail++;
            $display("FAIL noq_pulse_count: %0d pulses, required 1", rises);
        end
        n_checks++;
        if (overflow !== 1'b1) begin
            n_fail++;
            $display("FAIL noq_overflow: %b, required 1", overflow);
        end
        n_checks++;
        if (pending !== 2'd0) begin
            n_fail++;
            $display("FAIL noq_pending: %0d, required 0", pending);
        end
    endtask
`endif

    task automatic test_back_to_back();
        trigger = 1'b0;
        tick(); tick(); tick();
        trigger = 1'b1;
        tick();
        trigger = 1'b0;
        for (int j = 1; j <= 4; j++) tick();
        n_checks++;
        if (pulse_out !== 1'b0 || busy !== 1'b1) begin
            n_fail++;
            $display("FAIL final_gap_state: pulse=%b busy=%b, required 0 1", pulse_out, busy);
        end
        trigger = 1'b1;
        tick();
        n_checks++;
        if (pulse_out !== 1'b1) begin
            n_fail++;
            $display("FAIL final_gap_restart: pulse=%b, required 1", pulse_out);
        end
        trigger = 1'b0;
        for (int j = 0; j < 8; j++) tick();
    endtask

`ifdef PULSE_STRETCHER_QUEUE_EN
    task automatic test_queue();
        int rises = 0, low_run = 0;
        logic prev = 1'b0;
        for (int k = 0; k < 80; k++) begin
            trigger_l = (k <= 10 && k % 2 == 0);
            tick();
            if (k == 6) begin
                n_checks++;
                if (pending_l !== 2'd3 || overflow_l !== 1'b0) begin
                    n_fail++;
                    $display("FAIL queue_fill: pending=%0d overflow=%b, required 3 0", pending_l, overflow_l);
                end
            end
            if (k == 10) begin
                n_checks++;
                if (pending_l !== 2'd3 || overflow_l !== 1'b1) begin
                    n_fail++;
                    $display("FAIL queue_saturate: pending=%0d overflow=%b, required 3 1", pending_l, overflow_l);
                end
            end
            if (pulse_l === 1'b1 && prev === 1'b0) begin
                if (rises > 0) begin
                    n_checks++;
                    if (low_run !== 3) begin
                        n_fail++;
                        $display("FAIL queue_gap %0d: low for %0d cycles, required 3", rises, low_run);
                    end
                end
                rises++;
            end
            low_run = (pulse_l === 1'b1) ? 0 : low_run + 1;
            prev = pulse_l;
        end
        n_checks++;
        if (rises !== 4) begin
            n_fail++;
            $display("FAIL queue_pulse_count: %0d pulses, required 4", rises);
        end
        n_checks++;
        if (pending_l !== 2'd0 || busy_l !== 1'b0) begin
            n_fail++;
            $display("FAIL queue_drained: pending=%0d busy=%b, required 0 0", pending_l, busy_l);
        end
    endtask
`endif

    task automatic test_reset_mid_active();
        logic [1:0] exp_pend;
`ifdef PULSE_STRETCHER_QUEUE_EN
        exp_pend = 2'd2;
`else
        exp_pend = 2'd0;
`endif
        trigger_l = 1'b0;
        tick(); tick();
        for (int k = 0; k < 5; k++) begin
            trigger_l = (k % 2 == 0);
            tick();
        end
        n_checks++;
        if (pulse_l !== 1'b1 || pending_l !== exp_pend || overflow_l !== 1'b1) begin
            n_fail++;
            $display("FAIL pre_reset: pulse=%b pending=%0d overflow=%b, required 1 %0d 1",
                     pulse_l, pending_l, overflow_l, exp_pend);
        end
        trigger_l = 1'b0;
        reset = 1'b1;
        tick();
        n_checks++;
        if (pulse_l !== 1'b0 || pending_l !== 2'd0 || overflow_l !== 1'b0 || busy_l !== 1'b0) begin
            n_fail++;
            $display("FAIL mid_reset: pulse=%b pending=%0d overflow=%b busy=%b, required 0 0 0 0",
                     pulse_l, pending_l, overflow_l, busy_l);
        end
        reset = 1'b0;
        tick(); tick();
        n_checks++;
        if (pulse_l !== 1'b0 || busy_l !== 1'b0) begin
            n_fail++;
            $display("FAIL post_reset_idle: pulse=%b busy=%b, required 0 0", pulse_l, busy_l);
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_clk_enable();
`ifdef PULSE_STRETCHER_QUEUE_EN
        test_queue();
`else
        test_no_queue();
`endif
        test_back_to_back();
        test_reset_mid_active();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
